imem_uart_loader: RTL and testbench

- Writes program images into instruction memory, which the CPU core only ever reads.
- Receives a length-prefixed byte stream over a UART RX line and assembles little-endian 32-bit words.
- Issues one-cycle write strobes to the instruction memory's write port at byte addresses 0, 4, 8, ...
- Holds the CPU in reset (cpu_hold) while a load is in progress.

---
 rtl/imem_uart_loader.sv | 269 ++++++++++++++++++++++++++
 tb/tb_imem_uart_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_uart_loader.sv
// UART program loader: receives a length-prefixed little-endian byte stream
// and writes 32-bit words into instruction memory while holding the CPU in reset.
module imem_uart_loader #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DEPTH_WORDS  = 256,
   parameter int TIMEOUT_CLKS = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_start,
   input  logic        uart_rx,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code,
   output logic [15:0] word_count
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int TMO_W = $clog2(TIMEOUT_CLKS);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);
   localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
   localparam logic [16:0]      DEPTH_L   = 17'(DEPTH_WORDS);

   localparam logic [1:0] ERR_FRAME   = 2'b01;
   localparam logic [1:0] ERR_LENGTH  = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE, S_ERR} state_t;

   logic             sync1_r;
   logic             sync2_r;
   logic             rx_prev_r;
   rx_state_t        rx_state_r;
   logic [CNT_W-1:0] rx_cnt_r;
   logic [2:0]       rx_bit_r;
   logic [7:0]       rx_shift_r;
   logic [7:0]       rx_byte_r;
   logic             byte_valid_r;
   logic             frame_err_r;

   state_t           state_r;
   logic [15:0]      len_r;
   logic [15:0]      idx_r;
   logic [1:0]       lane_r;
   logic [23:0]      word_r;
   logic [TMO_W-1:0] tmo_r;

   logic [15:0]      idx_nx_s;
   logic [15:0]      len_nx_s;
   logic             len_bad_s;

   assign idx_nx_s  = idx_r + 16'd1;
   assign len_nx_s  = {rx_byte_r, len_r[7:0]};
   assign len_bad_s = (len_nx_s == 16'd0) || ({1'b0, len_nx_s} > DEPTH_L);

   // Synchronise uart_rx and keep the previous sample for falling-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r   <= 1'b1;
         sync2_r   <= 1'b1;
         rx_prev_r <= 1'b1;
      end else begin
         sync1_r   <= uart_rx;
         sync2_r   <= sync1_r;
         rx_prev_r <= sync2_r;
      end
   end

   // 8N1 receiver: start-bit recheck at half bit, then sample mid-bit LSB first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state_r   <= RX_IDLE;
         rx_cnt_r     <= '0;
         rx_bit_r     <= 3'd0;
         rx_shift_r   <= 8'd0;
         rx_byte_r    <= 8'd0;
         byte_valid_r <= 1'b0;
         frame_err_r  <= 1'b0;
      end else begin
         byte_valid_r <= 1'b0;
         frame_err_r  <= 1'b0;
         case (rx_state_r)
            RX_IDLE: begin
               rx_cnt_r <= '0;
               if (rx_prev_r && !sync2_r) begin
                  rx_state_r <= RX_START;
               end
            end
            RX_START: begin
               if (rx_cnt_r == HALF_LAST) begin
                  rx_cnt_r <= '0;
                  rx_bit_r <= 3'd0;
                  rx_state_r <= sync2_r ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_r <= rx_cnt_r + CNT_ONE;
               end
            end
            RX_DATA: begin
               if (rx_cnt_r == BIT_LAST) begin
                  rx_cnt_r   <= '0;
                  rx_shift_r <= {sync2_r, rx_shift_r[7:1]};
                  if (rx_bit_r == 3'd7) begin
                     rx_state_r <= RX_STOP;
                  end else begin
                     rx_bit_r <= rx_bit_r + 3'd1;
                  end
               end else begin
                  rx_cnt_r <= rx_cnt_r + CNT_ONE;
               end
            end
            RX_STOP: begin
               if (rx_cnt_r == BIT_LAST) begin
                  rx_cnt_r   <= '0;
                  rx_state_r <= RX_IDLE;
                  if (sync2_r) begin
                     byte_valid_r <= 1'b1;
                     rx_byte_r    <= rx_shift_r;
                  end else begin
                     frame_err_r <= 1'b1;
                  end
               end else begin
                  rx_cnt_r <= rx_cnt_r + CNT_ONE;
               end
            end
            default: begin
               rx_state_r <= RX_IDLE;
               rx_cnt_r   <= '0;
            end
         endcase
      end
   end

   // Load sequencer: length header, word assembly, memory strobes and status
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= S_IDLE;
         len_r      <= 16'd0;
         idx_r      <= 16'd0;
         lane_r     <= 2'd0;
         word_r     <= 24'd0;
         tmo_r      <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= 32'd0;
         imem_wdata <= 32'd0;
         cpu_hold   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_code   <= 2'b00;
         word_count <= 16'd0;
      end else begin
         imem_we <= 1'b0;
         case (state_r)
            S_IDLE, S_DONE, S_ERR: begin
               if (ld_start) begin
                  state_r    <= S_LEN_LO;
                  busy       <= 1'b1;
                  cpu_hold   <= 1'b1;
                  done       <= 1'b0;
                  err        <= 1'b0;
                  err_code   <= 2'b00;
                  word_count <= 16'd0;
                  idx_r      <= 16'd0;
                  lane_r     <= 2'd0;
                  tmo_r      <= '0;
               end
            end
            S_LEN_LO: begin
               tmo_r <= '0;
               if (frame_err_r) begin
                  state_r  <= S_ERR;
                  busy     <= 1'b0;
                  cpu_hold <= 1'b0;
                  err      <= 1'b1;
                  err_code <= ERR_FRAME;
               end else if (byte_valid_r) begin
                  len_r[7:0] <= rx_byte_r;
                  state_r    <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (frame_err_r) begin
                  state_r  <= S_ERR;
                  busy     <= 1'b0;
                  cpu_hold <= 1'b0;
                  err      <= 1'b1;
                  err_code <= ERR_FRAME;
               end else if (byte_valid_r) begin
                  len_r <= len_nx_s;
                  tmo_r <= '0;
                  if (len_bad_s) begin
                     state_r  <= S_ERR;
                     busy     <= 1'b0;
                     cpu_hold <= 1'b0;
                     err      <= 1'b1;
                     err_code <= ERR_LENGTH;
                  end else begin
                     state_r <= S_DATA;
                     idx_r   <= 16'd0;
                     lane_r  <= 2'd0;
                  end
               end else if (tmo_r == TMO_LAST) begin
                  state_r  <= S_ERR;
                  busy     <= 1'b0;
                  cpu_hold <= 1'b0;
                  err      <= 1'b1;
                  err_code <= ERR_TIMEOUT;
               end else begin
                  tmo_r <= tmo_r + TMO_ONE;
               end
            end
            S_DATA: begin
               if (frame_err_r) begin
                  state_r  <= S_ERR;
                  busy     <= 1'b0;
                  cpu_hold <= 1'b0;
                  err      <= 1'b1;
                  err_code <= ERR_FRAME;
               end else if (byte_valid_r) begin
                  tmo_r  <= '0;
                  lane_r <= lane_r + 2'd1;
                  case (lane_r)
                     2'd0: word_r[7:0]   <= rx_byte_r;
                     2'd1: word_r[15:8]  <= rx_byte_r;
                     2'd2: word_r[23:16] <= rx_byte_r;
                     default: begin
                        // Top byte completes the word: strobe it out directly
                        imem_we    <= 1'b1;
                        imem_addr  <= {14'd0, idx_r, 2'b00};
                        imem_wdata <= {rx_byte_r, word_r};
                        word_count <= idx_nx_s;
                        idx_r      <= idx_nx_s;
                        if (idx_nx_s == len_r) begin
                           state_r  <= S_DONE;
                           busy     <= 1'b0;
                           cpu_hold <= 1'b0;
                           done     <= 1'b1;
                        end
                     end
                  endcase
               end else if (tmo_r == TMO_LAST) begin
                  state_r  <= S_ERR;
                  busy     <= 1'b0;
                  cpu_hold <= 1'b0;
                  err      <= 1'b1;
                  err_code <= ERR_TIMEOUT;
               end else begin
                  tmo_r <= tmo_r + TMO_ONE;
               end
            end
            default: begin
               state_r  <= S_IDLE;
               busy     <= 1'b0;
               cpu_hold <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader with small parameters (4 clk/bit,
// 8-word memory, 200-clk timeout); memory strobes are logged by a monitor.
module tb_imem_uart_loader;

   localparam int CPB = 4;

   logic        clk;
   logic        rst;
   logic        ld_start;
   logic        uart_rx;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic [15:0] word_count;

   int          n_total;
   int          n_pass;
   int          we_total;
   logic [31:0] we_addr [16];
   logic [31:0] we_data [16];
   int          base;

   imem_uart_loader #(
      .CLKS_PER_BIT(CPB),
      .DEPTH_WORDS (8),
      .TIMEOUT_CLKS(200)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ld_start  (ld_start),
      .uart_rx   (uart_rx),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .imem_wdata(imem_wdata),
      .cpu_hold  (cpu_hold),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_code  (err_code),
      .word_count(word_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Log every write strobe away from the active edge
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         if (we_total < 16) begin
            we_addr[we_total] <= imem_addr;
            we_data[we_total] <= imem_wdata;
         end
         we_total <= we_total + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stop_bit;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
   endtask

   task automatic arm();
      @(negedge clk);
      ld_start = 1'b1;
      @(negedge clk);
      ld_start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      n_total  = 0;
      n_pass   = 0;
      we_total = 0;
      rst      = 1'b1;
      ld_start = 1'b0;
      uart_rx  = 1'b1;
      idle(3);
      chk("rst_status", {27'd0, imem_we, cpu_hold, busy, done, err}, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
      rst = 1'b0;
      idle(3);
      chk("idle_status", {14'd0, err_code, word_count}, 32'd0);

      // Two-word load
      base = we_total;
      arm();
      chk("arm_busy_hold", {30'd0, busy, cpu_hold}, 32'd3);
      send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
      send_byte(8'h13, 1'b1); send_byte(8'h05, 1'b1);
      send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
      send_byte(8'h93, 1'b1); send_byte(8'h05, 1'b1);
      send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
      idle(10);
      chk("load2_strobes", 32'(we_total - base), 32'd2);
      chk("load2_addr0", we_addr[base], 32'h0000_0000);
      chk("load2_data0", we_data[base], 32'h0010_0513);
      chk("load2_addr1", we_addr[base+1], 32'h0000_0004);
      chk("load2_data1", we_data[base+1], 32'h0100_0593);
      chk("load2_status", {27'd0, done, cpu_hold, busy, err, imem_we}, 32'h10);
      chk("load2_count", {16'd0, word_count}, 32'd2);

      // Length too large, then zero length
      base = we_total;
      arm();
      chk("rearm_clear", {26'd0, done, err, err_code, busy, cpu_hold}, 32'h3);
      chk("rearm_count", {16'd0, word_count}, 32'd0);
      send_byte(8'h09, 1'b1); send_byte(8'h00, 1'b1);
      idle(10);
      chk("len9_err", {29'd0, err, err_code}, 32'h6);
      chk("len9_busy", {30'd0, busy, cpu_hold}, 32'd0);
      arm();
      send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
      idle(10);
      chk("len0_err", {29'd0, err, err_code}, 32'h6);
      chk("len_strobes", 32'(we_total - base), 32'd0);

      // Timeout mid-word
      base = we_total;
      arm();
      send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
      send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
      idle(100);
      chk("tmo_not_yet", {29'd0, err, busy, done}, 32'h2);
      idle(150);
      chk("tmo_err", {29'd0, err, err_code}, 32'h7);
      chk("tmo_strobes", 32'(we_total - base), 32'd0);
      chk("tmo_count", {16'd0, word_count}, 32'd0);

      // Framing error on the third data byte
      base = we_total;
      arm();
      send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
      send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b0);
      idle(10);
      chk("frame_err", {29'd0, err, err_code}, 32'h5);
      chk("frame_strobes", 32'(we_total - base), 32'd0);

      // One-clock glitch in LEN_LO, then a valid one-word load
      base = we_total;
      arm();
      idle(4);
      uart_rx = 1'b0;
      @(negedge clk);
      uart_rx = 1'b1;
      idle(10);
      send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
      send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1);
      send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
      idle(10);
      chk("glitch_strobes", 32'(we_total - base), 32'd1);
      chk("glitch_addr", we_addr[base], 32'h0000_0000);
      chk("glitch_data", we_data[base], 32'hDEAD_BEEF);
      chk("glitch_status", {29'd0, done, err, busy}, 32'h4);

      // Reset in the middle of a word, then a clean reload
      base = we_total;
      arm();
      send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
      send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1);
      idle(3);
      rst = 1'b1;
      #1;
      chk("midrst_status", {25'd0, imem_we, cpu_hold, busy, done, err, err_code}, 32'd0);
      chk("midrst_count", {16'd0, word_count}, 32'd0);
      idle(2);
      rst = 1'b0;
      idle(3);
      chk("midrst_strobes", 32'(we_total - base), 32'd0);
      arm();
      send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
      send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1);
      send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
      idle(10);
      chk("reload_strobes", 32'(we_total - base), 32'd1);
      chk("reload_addr", we_addr[base], 32'h0000_0000);
      chk("reload_data", we_data[base], 32'h1234_5678);
      chk("reload_status", {28'd0, done, err, busy, cpu_hold}, 32'h8);
      chk("reload_count", {16'd0, word_count}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
